// File: rtl/srl_fifo_pkg.sv
// Shared types and elaboration-time helpers for the SRL FIFO with thresholds.
// Sizing functions take module parameters as arguments, so every instance derives its own widths.
package srl_fifo_pkg;

  typedef enum logic [1:0] {
    HEAD_HOLD     = 2'd0,
    HEAD_FROM_SRL = 2'd1,
    HEAD_FROM_DIN = 2'd2,
    HEAD_CLEAR    = 2'd3
  } head_src_e;

  localparam int MIN_DEPTH = 32'sd2;

  function automatic int clog2(input int value);
    int res;
    res = 32'sd0;
    for (int w = 32'sd1; w < value; w = w * 32'sd2) begin
      res = res + 32'sd1;
    end
    return res;
  endfunction

  function automatic int cap_of(input int depth, input int out_reg);
    return depth + out_reg;
  endfunction

  function automatic int count_width(input int depth, input int out_reg);
    return clog2(cap_of(depth, out_reg) + 32'sd1);
  endfunction

  function automatic bit params_ok(input int depth, input int out_reg,
                                   input int ae_thr, input int af_thr);
    return (depth >= MIN_DEPTH) && (out_reg >= 32'sd0) && (out_reg <= 32'sd1) &&
           (ae_thr >= 32'sd0) && (ae_thr < af_thr) &&
           (af_thr <= cap_of(depth, out_reg));
  endfunction

endpackage

// File: rtl/srl_fifo_storage.sv
// Shift-register storage: newest entry at index 0, read tap selected by addr.
// No reset on the array so that it maps onto SRL primitives.
module srl_fifo_storage
  import srl_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // shift every entry one place deeper on a write
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_r[i] <= mem_r[i-1];
      end
    end
  end

  assign dout = mem_r[addr];

endmodule

// File: rtl/srl_fifo_thresh_chk.sv
// Run-time checks for srl_fifo_thresh: parameter legality and occupancy bound.
module srl_fifo_thresh_chk
  import srl_fifo_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int OUT_REG = 0,
  parameter int AF_THR  = 12,
  parameter int AE_THR  = 2,
  parameter int CW      = count_width(DEPTH, OUT_REG)
) (
  input logic          clk,
  input logic          reset,
  input logic [CW-1:0] count
);

  localparam int CAP = cap_of(DEPTH, OUT_REG);

  // occupancy must never exceed capacity; thresholds must be consistent
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (params_ok(DEPTH, OUT_REG, AE_THR, AF_THR));
      assert (count <= CW'(CAP));
    end
  end

endmodule

// File: rtl/srl_fifo_thresh.sv
// SRL FIFO with registered full/empty/almost flags, occupancy count and an
// optional registered head stage (OUT_REG=1 adds one entry of capacity).
module srl_fifo_thresh
  import srl_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = clog2(DEPTH),
  parameter int OUT_REG    = 0,
  parameter int AF_THR     = 12,
  parameter int AE_THR     = 2
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       if_write_ce,
  input  logic                                       if_write,
  input  logic [DATA_WIDTH-1:0]                      if_din,
  output logic                                       if_full_n,
  output logic                                       if_almost_full_n,
  input  logic                                       if_read_ce,
  input  logic                                       if_read,
  output logic [DATA_WIDTH-1:0]                      if_dout,
  output logic                                       if_empty_n,
  output logic                                       if_almost_empty_n,
  output logic [count_width(DEPTH, OUT_REG)-1:0]     if_count
);

  localparam int CAP = cap_of(DEPTH, OUT_REG);
  localparam int CW  = count_width(DEPTH, OUT_REG);
  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);
  localparam logic [CW-1:0] CAP_C   = CW'(CAP);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THR);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THR);

  logic                  push_s;
  logic                  pop_s;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_nxt_s;
  logic                  full_n_r;
  logic                  empty_n_r;
  logic                  af_n_r;
  logic                  ae_n_r;
  logic                  srl_we_s;
  logic [ADDR_WIDTH-1:0] srl_addr_s;
  logic [DATA_WIDTH-1:0] srl_dout_s;

  // handshakes only use registered flags, so no request-to-flag combinational path exists
  assign push_s = if_write & if_write_ce & full_n_r;
  assign pop_s  = if_read  & if_read_ce  & empty_n_r;

  // next occupancy from the accepted handshakes
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // count and all flags registered from the next count
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r   <= '0;
      full_n_r  <= 1'b1;
      empty_n_r <= 1'b0;
      af_n_r    <= 1'b1;
      ae_n_r    <= 1'b0;
    end else begin
      count_r   <= count_nxt_s;
      full_n_r  <= (count_nxt_s != CAP_C);
      empty_n_r <= (count_nxt_s != '0);
      af_n_r    <= (count_nxt_s < AF_C);
      ae_n_r    <= (count_nxt_s > AE_C);
    end
  end

  assign if_count          = count_r;
  assign if_full_n         = full_n_r;
  assign if_empty_n        = empty_n_r;
  assign if_almost_full_n  = af_n_r;
  assign if_almost_empty_n = ae_n_r;

  srl_fifo_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_storage (
    .clk  (clk),
    .we   (srl_we_s),
    .addr (srl_addr_s),
    .din  (if_din),
    .dout (srl_dout_s)
  );

  generate
    if (OUT_REG == 0) begin : g_direct
      // the whole occupancy lives in the SRL, oldest entry sits at count-1
      assign srl_we_s   = push_s;
      assign srl_addr_s = ADDR_WIDTH'(count_r - CNT_ONE);
      assign if_dout    = srl_dout_s;
    end else begin : g_head
      localparam int SW = clog2(DEPTH + 32'sd1);
      localparam logic [SW-1:0] SRL_ONE = SW'(32'd1);

      logic [SW-1:0]         srl_cnt_r;
      logic [DATA_WIDTH-1:0] head_r;
      logic                  head_valid_r;
      logic                  srl_pop_s;
      head_src_e             head_src_s;

      // refill the head whenever it is empty or leaving; bypass the SRL when it holds nothing
      always_comb begin
        head_src_s = HEAD_HOLD;
        srl_pop_s  = 1'b0;
        srl_we_s   = push_s;
        if (!head_valid_r || pop_s) begin
          if (srl_cnt_r != '0) begin
            head_src_s = HEAD_FROM_SRL;
            srl_pop_s  = 1'b1;
          end else if (push_s) begin
            head_src_s = HEAD_FROM_DIN;
            srl_we_s   = 1'b0;
          end else begin
            head_src_s = HEAD_CLEAR;
          end
        end else begin
          head_src_s = HEAD_HOLD;
        end
      end

      assign srl_addr_s = ADDR_WIDTH'(srl_cnt_r - SRL_ONE);
      assign if_dout    = head_r;

      // SRL occupancy and head register update
      always_ff @(posedge clk) begin
        if (reset) begin
          srl_cnt_r    <= '0;
          head_r       <= '0;
          head_valid_r <= 1'b0;
        end else begin
          case ({srl_we_s, srl_pop_s})
            2'b10:   srl_cnt_r <= srl_cnt_r + SRL_ONE;
            2'b01:   srl_cnt_r <= srl_cnt_r - SRL_ONE;
            default: srl_cnt_r <= srl_cnt_r;
          endcase
          case (head_src_s)
            HEAD_FROM_SRL: begin
              head_r       <= srl_dout_s;
              head_valid_r <= 1'b1;
            end
            HEAD_FROM_DIN: begin
              head_r       <= if_din;
              head_valid_r <= 1'b1;
            end
            HEAD_CLEAR:    head_valid_r <= 1'b0;
            default:       head_valid_r <= head_valid_r;
          endcase
        end
      end
    end
  endgenerate

  srl_fifo_thresh_chk #(
    .DEPTH   (DEPTH),
    .OUT_REG (OUT_REG),
    .AF_THR  (AF_THR),
    .AE_THR  (AE_THR),
    .CW      (CW)
  ) u_chk (
    .clk   (clk),
    .reset (reset),
    .count (count_r)
  );

endmodule

// File: tb/tb_srl_fifo_thresh.sv
// Directed bench: one stimulus stream drives an OUT_REG=0 (CAP 4) and an OUT_REG=1 (CAP 5) instance.
module tb_srl_fifo_thresh;

  logic       clk = 1'b0;
  logic       reset;
  logic       write_ce, write, read_ce, read;
  logic [7:0] din;
  logic       full_n [2];
  logic       af_n   [2];
  logic       empty_n[2];
  logic       ae_n   [2];
  logic [7:0] dout   [2];
  logic [2:0] count  [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  srl_fifo_thresh #(.DATA_WIDTH(8), .DEPTH(4), .OUT_REG(0), .AF_THR(3), .AE_THR(1)) u_dut0 (
    .clk(clk), .reset(reset), .if_write_ce(write_ce), .if_write(write), .if_din(din),
    .if_full_n(full_n[0]), .if_almost_full_n(af_n[0]), .if_read_ce(read_ce), .if_read(read),
    .if_dout(dout[0]), .if_empty_n(empty_n[0]), .if_almost_empty_n(ae_n[0]), .if_count(count[0]));

  srl_fifo_thresh #(.DATA_WIDTH(8), .DEPTH(4), .OUT_REG(1), .AF_THR(3), .AE_THR(1)) u_dut1 (
    .clk(clk), .reset(reset), .if_write_ce(write_ce), .if_write(write), .if_din(din),
    .if_full_n(full_n[1]), .if_almost_full_n(af_n[1]), .if_read_ce(read_ce), .if_read(read),
    .if_dout(dout[1]), .if_empty_n(empty_n[1]), .if_almost_empty_n(ae_n[1]), .if_count(count[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected flags follow from the hand-computed count and each instance's capacity
  task automatic chk_state(input string tag, input int c0, input int c1);
    for (int d = 0; d < 2; d++) begin
      int c;
      int cap;
      c   = (d == 0) ? c0 : c1;
      cap = 4 + d;
      chk($sformatf("%s.d%0d.count", tag, d),   32'(count[d]),   c);
      chk($sformatf("%s.d%0d.full_n", tag, d),  32'(full_n[d]),  32'(c != cap));
      chk($sformatf("%s.d%0d.empty_n", tag, d), 32'(empty_n[d]), 32'(c != 0));
      chk($sformatf("%s.d%0d.af_n", tag, d),    32'(af_n[d]),    32'(c < 3));
      chk($sformatf("%s.d%0d.ae_n", tag, d),    32'(ae_n[d]),    32'(c > 1));
    end
  endtask

  task automatic chk_dout(input string tag, input logic [7:0] exp);
    chk({tag, ".d0.dout"}, 32'(dout[0]), 32'(exp));
    chk({tag, ".d1.dout"}, 32'(dout[1]), 32'(exp));
  endtask

  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    write = w;
    din   = d;
    read  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t3_exp[5];
    t3_exp = '{8'h31, 8'h32, 8'hA0, 8'hA1, 8'hA2};
    reset = 1'b1; write_ce = 1'b1; read_ce = 1'b1; write = 1'b0; read = 1'b0; din = 8'h00;

    // 1: reset state, ordered write/read of four entries
    do_reset();
    chk_state("rst", 0, 0);
    chk("rst.d1.head", 32'(dout[1]), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
      chk_state("t1.wr", i + 1, i + 1);
      chk_dout("t1.wr", 8'h11);
    end
    for (int i = 0; i < 4; i++) begin
      chk_dout("t1.rd", 8'(8'h11 * (i + 1)));
      cyc(1'b0, 8'h00, 1'b1);
      chk_state("t1.rd", 3 - i, 3 - i);
    end

    // 2: writes beyond capacity are dropped
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, (k <= 5) ? 8'(k) : 8'h55, 1'b0);
      chk_state("t2.fill", (k < 4) ? k : 4, (k < 5) ? k : 5);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 4) chk("t2.drain.d0.dout", 32'(dout[0]), 32'(i + 1));
      chk("t2.drain.d1.dout", 32'(dout[1]), 32'(i + 1));
      cyc(1'b0, 8'h00, 1'b1);
      chk_state("t2.drain", (i < 3) ? 3 - i : 0, 4 - i);
    end

    // 3: simultaneous push and pop at count 2
    do_reset();
    cyc(1'b1, 8'h31, 1'b0);
    cyc(1'b1, 8'h32, 1'b0);
    chk_state("t3.pre", 2, 2);
    for (int i = 0; i < 5; i++) begin
      chk_dout("t3.pp", t3_exp[i]);
      cyc(1'b1, 8'(8'hA0 + i), 1'b1);
      chk_state("t3.pp", 2, 2);
    end
    chk_dout("t3.tail0", 8'hA3);
    cyc(1'b0, 8'h00, 1'b1);
    chk_dout("t3.tail1", 8'hA4);
    cyc(1'b0, 8'h00, 1'b1);
    chk_state("t3.end", 0, 0);

    // 4: threshold sweep; before each edge the flags still reflect the old count
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      write = 1'b1; din = 8'(k); read = 1'b0;
      #1;
      chk_state("t4.up.pre", (k - 1 < 4) ? k - 1 : 4, k - 1);
      @(posedge clk);
      #1;
      chk_state("t4.up", (k < 4) ? k : 4, k);
    end
    for (int k = 1; k <= 5; k++) begin
      write = 1'b0; read = 1'b1;
      #1;
      chk_state("t4.dn.pre", (k < 2) ? 4 : 5 - k, 6 - k);
      @(posedge clk);
      #1;
      chk_state("t4.dn", (k < 4) ? 4 - k : 0, 5 - k);
    end

    // 5: reset mid-transfer drops the concurrent push
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
    chk_state("t5.pre", 3, 3);
    reset = 1'b1;
    cyc(1'b1, 8'h99, 1'b0);
    reset = 1'b0;
    chk_state("t5.rst", 0, 0);
    chk("t5.rst.d1.head", 32'(dout[1]), 32'h0);
    cyc(1'b1, 8'h7E, 1'b0);
    chk_state("t5.wr", 1, 1);
    chk_dout("t5.wr", 8'h7E);
    cyc(1'b0, 8'h00, 1'b1);
    chk_state("t5.rd", 0, 0);

    // 6: read CE low blocks pops only; write CE low blocks pushes only
    read_ce = 1'b0;
    cyc(1'b1, 8'h61, 1'b1);
    chk_state("t6.w1", 1, 1);
    cyc(1'b1, 8'h62, 1'b1);
    chk_state("t6.w2", 2, 2);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk_state("t6.hold", 2, 2);
    write_ce = 1'b0;
    cyc(1'b1, 8'h63, 1'b1);
    chk_state("t6.noce", 2, 2);
    write_ce = 1'b1;
    read_ce  = 1'b1;
    chk_dout("t6.rd0", 8'h61);
    cyc(1'b0, 8'h00, 1'b1);
    chk_state("t6.rd0", 1, 1);
    chk_dout("t6.rd1", 8'h62);
    cyc(1'b0, 8'h00, 1'b1);
    chk_state("t6.rd1", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
